// File: rtl/mem_pkg.sv
// Shared types for the load/store unit: access-type encodings, FSM state set
// and the access-size helper.
package mem_pkg;

  typedef enum logic [2:0] {
    RW_BYTE    = 3'b000,
    RW_HALF    = 3'b001,
    RW_WORD    = 3'b010,
    RW_DWORD   = 3'b011,
    RW_BYTE_U  = 3'b100,
    RW_HALF_U  = 3'b101,
    RW_WORD_U  = 3'b110,
    RW_INVALID = 3'b111
  } rw_type_e;

  typedef enum logic [2:0] {
    MAU_IDLE  = 3'd0,
    MAU_REQ0  = 3'd1,
    MAU_WAIT0 = 3'd2,
    MAU_REQ1  = 3'd3,
    MAU_WAIT1 = 3'd4,
    MAU_RESP  = 3'd5
  } mau_state_e;

  // Access size in bytes: 1, 2, 4 or 8 from the low two type bits.
  function automatic logic [3:0] size_bytes(input rw_type_e t);
    return 4'd1 << t[1:0];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response and memory beat signals of the load/store unit.
// slave = the unit's view, master = the CPU plus memory surrounding it.
interface mem_access_unit_if
  import mem_pkg::*;
#(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  rw_type_e        req_type;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_fault;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic [NB-1:0]   mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wdata,
    input  resp_ready,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_fault,
    output mem_req_valid, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_type, req_addr, req_wdata,
    output resp_ready,
    output mem_req_ready, mem_rvalid, mem_rdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_fault,
    input  mem_req_valid, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane math: byte-enable mask over two beats, split detection,
// store-data steering for the selected beat and load extraction/extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SPLIT_EN = 1'b0,
  localparam int NB      = XLEN / 8,
  localparam int OFFW    = $clog2(XLEN / 8)
) (
  input  rw_type_e        rw_type,
  input  logic [OFFW-1:0] off,
  input  logic            beat_sel,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] beat0,
  input  logic [XLEN-1:0] beat1,
  output logic [NB-1:0]   be,
  output logic            split,
  output logic [XLEN-1:0] wbeat,
  output logic [XLEN-1:0] rdata
);

  logic [3:0]        size;
  logic [2*NB-1:0]   mask2;
  logic [2*XLEN-1:0] wide_w;
  logic [XLEN-1:0]   raw;
  logic [6:0]        nbits;
  logic [6:0]        shamt;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   zext;
  logic signed [XLEN-1:0] sext;

  assign size = size_bytes(rw_type);

  // Lane gi is enabled when it falls in [off, off+size); the upper NB lanes
  // belong to the second beat and exist only when splitting is built in.
  genvar gi;
  generate
    for (gi = 0; gi < 2*NB; gi++) begin : g_mask
      if (gi >= NB && !SPLIT_EN) begin : g_tied
        assign mask2[gi] = 1'b0;
      end else begin : g_lane
        assign mask2[gi] = (5'(gi) >= 5'(off)) && (5'(gi) < 5'(off) + 5'(size));
      end
    end
  endgenerate

  assign split  = |mask2[2*NB-1:NB];
  assign be     = beat_sel ? mask2[2*NB-1:NB] : mask2[NB-1:0];
  assign wide_w = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  assign wbeat  = beat_sel ? wide_w[2*XLEN-1:XLEN] : wide_w[XLEN-1:0];
  assign raw    = XLEN'({beat1, beat0} >> {off, 3'b000});

  // Truncate by shifting the field to the top, then shift back arithmetically
  // or logically to get sign or zero extension.
  always_comb begin
    case (rw_type[1:0])
      2'd0:    nbits = 7'd8;
      2'd1:    nbits = 7'd16;
      2'd2:    nbits = 7'd32;
      default: nbits = 7'd64;
    endcase
    shamt   = (nbits >= 7'(XLEN)) ? 7'd0 : 7'(XLEN) - nbits;
    shifted = raw << shamt;
    sext    = $signed(shifted) >>> shamt;
    zext    = shifted >> shamt;
    rdata   = rw_type[2] ? zext : sext;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Request/response load/store engine between MEM stage and data memory.
// Define MEM_MISALIGN_EN to split misaligned accesses into two aligned beats.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                clk,
  input logic                rst,
  mem_access_unit_if.slave   bus
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

`ifdef MEM_MISALIGN_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam logic [2:0] IDLE  = MAU_IDLE;
  localparam logic [2:0] REQ0  = MAU_REQ0;
  localparam logic [2:0] WAIT0 = MAU_WAIT0;
  localparam logic [2:0] REQ1  = MAU_REQ1;
  localparam logic [2:0] WAIT1 = MAU_WAIT1;
  localparam logic [2:0] RESP  = MAU_RESP;

  logic [2:0]      state_reg, state_next;
  logic            we_reg;
  rw_type_e        type_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            fault_reg;
  logic [XLEN-1:0] beat0_reg;
  logic [XLEN-1:0] beat1_reg;

  logic [3:0]      req_size;
  logic            req_misaligned;
  logic            req_fault;
  logic            beat_sel;
  logic [NB-1:0]   be_w;
  logic            split_w;
  logic [XLEN-1:0] wbeat_w;
  logic [XLEN-1:0] rdata_w;
  logic [XLEN-1:0] beat0_addr;
  logic [XLEN-1:0] beat1_addr;

  // Rejected requests never reach memory, so the decision is made on the raw
  // request before anything is latched.
  always_comb begin
    req_size       = size_bytes(bus.req_type);
    req_misaligned = (bus.req_addr[3:0] & (req_size - 4'd1)) != 4'd0;
    req_fault      = (bus.req_type == RW_INVALID)
                   || (bus.req_we && bus.req_type[2])
                   || (req_misaligned && !SPLIT_EN);
    if (XLEN == 32 && (bus.req_type == RW_DWORD || bus.req_type == RW_WORD_U))
      req_fault = 1'b1;
  end

`ifdef MEM_MISALIGN_EN
  assign beat_sel = (state_reg == REQ1);
`else
  assign beat_sel = 1'b0;
`endif

  assign beat0_addr = {addr_reg[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign beat1_addr = beat0_addr + XLEN'(NB);

  mem_lane_align #(
    .XLEN     (XLEN),
    .SPLIT_EN (SPLIT_EN)
  ) u_align (
    .rw_type  (type_reg),
    .off      (addr_reg[OFFW-1:0]),
    .beat_sel (beat_sel),
    .wdata    (wdata_reg),
    .beat0    (beat0_reg),
    .beat1    (beat1_reg),
    .be       (be_w),
    .split    (split_w),
    .wbeat    (wbeat_w),
    .rdata    (rdata_w)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (bus.req_valid)     state_next = req_fault ? RESP : REQ0;
      REQ0:  if (bus.mem_req_ready) state_next = WAIT0;
      WAIT0: if (bus.mem_rvalid)    state_next = split_w ? REQ1 : RESP;
`ifdef MEM_MISALIGN_EN
      REQ1:  if (bus.mem_req_ready) state_next = WAIT1;
      WAIT1: if (bus.mem_rvalid)    state_next = RESP;
`endif
      RESP:  if (bus.resp_ready)    state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      type_reg  <= RW_BYTE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      fault_reg <= 1'b0;
      beat0_reg <= '0;
      beat1_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && bus.req_valid) begin
        we_reg    <= bus.req_we;
        type_reg  <= bus.req_type;
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
        fault_reg <= req_fault;
      end
      if (state_reg == WAIT0 && bus.mem_rvalid)
        beat0_reg <= bus.mem_rdata;
`ifdef MEM_MISALIGN_EN
      if (state_reg == WAIT1 && bus.mem_rvalid)
        beat1_reg <= bus.mem_rdata;
`endif
    end
  end

  // Outputs are forced to zero during reset; the payload is only driven while
  // a beat or response is actually being offered.
  always_comb begin
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_fault    = 1'b0;
    bus.resp_rdata    = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_be        = '0;
    bus.mem_wdata     = '0;
    if (!rst) begin
      bus.req_ready = (state_reg == IDLE);
      if (state_reg == REQ0 || state_reg == REQ1) begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = (state_reg == REQ1) ? beat1_addr : beat0_addr;
        bus.mem_be        = we_reg ? be_w : '0;
        bus.mem_wdata     = wbeat_w;
      end
      if (state_reg == RESP) begin
        bus.resp_valid = 1'b1;
        bus.resp_fault = fault_reg;
        bus.resp_rdata = (we_reg || fault_reg) ? '0 : rdata_w;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential load/store unit between the pipeline's MEM stage and the data memory port, replacing the purely combinational lane steering with a request/response engine. Provides byte-lane alignment, sign/zero extension and byte write enables for a parametrised data width. Tolerates a memory with variable grant and read latency, and optionally splits misaligned accesses into two aligned beats. One access is in flight at a time.

## Interface
- `XLEN`, 32: data/address width; legal values 32 or 64. `NB = XLEN/8` byte lanes.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: CPU access request.
- `req_ready` out 1: unit accepts a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_type` in 3: access type, encoded as `rw_type_e`.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-justified.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: CPU consumes the response.
- `resp_rdata` out XLEN: extended load data; 0 for stores and faults.
- `resp_fault` out 1: access rejected; no memory traffic was issued.
- `mem_req_valid` out 1: beat request to memory.
- `mem_req_ready` in 1: memory accepts the beat.
- `mem_addr` out XLEN: NB-aligned beat address.
- `mem_be` out NB: byte write enables; all 0 for reads.
- `mem_wdata` out XLEN: lane-steered store data.
- `mem_rvalid` in 1: beat completion. Returns read data for reads and is an acknowledge for writes. At most one outstanding beat.
- `mem_rdata` in XLEN: read beat data.

## Operation
- Encodings: BYTE 000, HALF 001, WORD 010, DWORD 011, BYTE_U 100, HALF_U 101, WORD_U 110. Size in bytes is `2^type[1:0]`.
- Faults:
  - DWORD or WORD_U when XLEN=32.
  - Any `_U` type on a store.
  - Encoding 111.
  - A misaligned access (`addr % size != 0`) when splitting is compiled out.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: `req_valid && req_ready` latches we/type/addr/wdata.
  - Faulting request goes to RESP with `resp_fault=1`.
  - Otherwise goes to REQ0.
- REQ0: `mem_req_valid=1` with the beat-0 address, enables and data. On `mem_req_ready` go to WAIT0.
- WAIT0: on `mem_rvalid`, capture `mem_rdata` into beat0. If split, go to REQ1; else go to RESP.
- REQ1 / WAIT1: same handshakes for beat 1 at beat-0 address + NB. Capture into beat1, then go to RESP.
- RESP: `resp_valid=1` is held until `resp_ready`, then return to IDLE. Response outputs are stable while held.
- Lane math:
  - `off = addr % NB`.
  - Enable mask on 2·NB bits: `((1<<size)-1) << off`. The low NB bits go to beat 0, the high NB bits to beat 1.
  - Split occurs when the high half of the mask is nonzero.
  - Store data: the 2·XLEN vector `wdata << 8·off`; low half in beat 0, high half in beat 1.
  - Load data: `({beat1,beat0} >> 8·off)`, truncated to size, then sign-extended (signed types) or zero-extended (`_U`).
- `mem_rvalid` outside WAIT0/WAIT1 is ignored.
- `mem_be` is 0 for reads.

## Timing
- Reset: FSM to IDLE; beat registers 0. While `rst` is high, all outputs are 0, including `req_ready`. `req_ready=1` from the first cycle after reset.
- Reset mid-access: the in-flight beat is abandoned and no response is produced. A late `mem_rvalid` is ignored because the FSM is in IDLE.
- Zero-wait memory (ready=1, rvalid the cycle after grant):
  - Aligned access: accept at T0; REQ0 at T1; rvalid at T2; `resp_valid` at T3.
  - Split access: `resp_valid` at T5.
  - Fault: `resp_valid` at T1.
- `mem_req_valid` and its payload stay stable until `mem_req_ready`.
- Back-to-back: a new request is accepted the cycle after the `resp_valid && resp_ready` handshake.
- Simultaneous `mem_req_ready` and `mem_rvalid` in REQx: `mem_rvalid` is ignored. Memory must not ack before grant.

## Configuration
- `MEM_MISALIGN_EN` defined: misaligned accesses are split into two beats as above.
- `MEM_MISALIGN_EN` undefined: the REQ1/WAIT1 logic is compiled out, and any misaligned access returns `resp_fault=1` with no memory traffic.

## Structure
- Package `mem_pkg`: `rw_type_e` enum (the encodings above), `mau_state_e` FSM enum, and the `size_bytes()` function.
- Sub-module `mem_lane_align`: purely combinational. Computes the enable mask, split flag, steered store beats and extended load result from type/offset/data. The FSM, handshakes and beat registers stay in `mem_access_unit`.

## Test plan
- XLEN=32, LW at 0x100: mem_rdata=0x8765_4321 → resp_rdata=0x8765_4321, fault=0, `resp_valid` at T3.
- LB at 0x103 with mem_rdata=0x80xx_xxxx → 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x102, wdata=0x0000_BEEF → mem_addr 0x100, mem_be=1100, mem_wdata[31:16]=0xBEEF.
- With `MEM_MISALIGN_EN`, SW at 0x101, wdata=0xAABBCCDD:
  - Beat 0: addr 0x100, be=1110, wdata=0xBBCCDDxx.
  - Beat 1: addr 0x104, be=0001, wdata[7:0]=0xAA.
  - LW of the same address reassembles 0xAABBCCDD.
- Without the macro, LH at 0x103 → fault=1 at T1 and no `mem_req_valid`. DWORD at XLEN=32 → fault.
- `mem_req_ready` held low 4 cycles, `resp_ready` low 2 cycles, `rst` pulsed in WAIT0:
  - Request payload and response are held stable throughout.
  - After the reset, FSM is IDLE with no response produced.
  - A stray `mem_rvalid` after the reset is ignored.
